// File: rtl/acc_store_unit_pkg.sv
//==============================================================================
// Module   : acc_store_unit_pkg
// Brief    : Shared constants and FSM encodings for the accumulator store unit.
//            Feature macro: STORE_TIMEOUT_EN (bus-beat timeout/abort).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package acc_store_unit_pkg;

  localparam int DEFAULT_DEPTH   = 2;
  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_TIMEOUT = 16;
  localparam int DATA_W          = 8;

  // Feature macros consumed by acc_store_unit:
  //   STORE_TIMEOUT_EN - abort a bus beat after TIMEOUT cycles without busAck
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } storeState_t;

endpackage

`default_nettype wire

// File: rtl/acc_store_unit_fifo.sv
//==============================================================================
// Module   : store_fifo
// Brief    : Synchronous FIFO with head and next-head peek, async reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module store_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = DEPTH + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Full is judged on the pre-edge count, so a push into a full FIFO is lost
  // even if the same edge pops.
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_doPush && !w_doPop)      r_count <= r_count + CNT_W'(1);
      else if (w_doPop && !w_doPush) r_count <= r_count - CNT_W'(1);
    end
  end

  assign head  = r_mem[r_rdPtr];
  assign next  = r_mem[r_rdPtr + PTR_W'(1)];
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/acc_store_unit.sv
//==============================================================================
// Module   : acc_store_unit
// Brief    : Executes ST/STN: queues {addr, data} and drains it over valid/ack.
//            Optional feature macro: STORE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module acc_store_unit
  import acc_store_unit_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] accData,
  input  logic              stEn,
  input  logic              stNeg,
  input  logic [ADDR_W-1:0] stAddr,
  output logic              stFull,
  output logic              stIdle,
  output logic              stOvf,
  output logic              busReq,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busData,
  input  logic              busAck,
  output logic              stErr
);

  localparam int CNT_W   = DEPTH + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  storeState_t        r_state;
  storeState_t        w_stateNext;
  logic [ENTRY_W-1:0] w_pushEntry;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_peek;
  logic [ENTRY_W-1:0] w_loadEntry;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_xfer;
  logic               w_abort;
  logic               w_load;
  logic [ADDR_W-1:0]  r_busAddr;
  logic [DATA_W-1:0]  r_busData;
  logic               r_stOvf;

  assign w_pushEntry = {stAddr, stNeg ? ~accData : accData};
  assign w_push      = stEn && !w_full;
  assign w_xfer      = (r_state == ST_REQ) && busAck;
  assign w_pop       = w_xfer || w_abort;

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (w_push),
    .pop    (w_pop),
    .wrData (w_pushEntry),
    .head   (w_head),
    .next   (w_peek),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  // The output register is reloaded on every pop that leaves work behind; a
  // store arriving into an otherwise drained FIFO is bypassed straight in so
  // back-to-back beats never see a bubble.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_loadEntry = w_head;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_stateNext = ST_REQ;
          w_load      = 1'b1;
          w_loadEntry = w_head;
        end else if (w_push) begin
          w_stateNext = ST_REQ;
          w_load      = 1'b1;
          w_loadEntry = w_pushEntry;
        end
      end
      ST_REQ: begin
        if (w_pop) begin
          if (w_count > CNT_W'(1)) begin
            w_load      = 1'b1;
            w_loadEntry = w_peek;
          end else if (w_push) begin
            w_load      = 1'b1;
            w_loadEntry = w_pushEntry;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_busAddr <= '0;
      r_busData <= '0;
      r_stOvf   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_load) begin
        r_busAddr <= w_loadEntry[ENTRY_W-1:DATA_W];
        r_busData <= w_loadEntry[DATA_W-1:0];
      end
      if (stEn && w_full) r_stOvf <= 1'b1;
    end
  end

`ifdef STORE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_stErr;

  // An ack on the timeout edge wins: the beat counts as transferred.
  assign w_abort = (r_state == ST_REQ) && !busAck &&
                   (r_waitCnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt <= '0;
      r_stErr   <= 1'b0;
    end else begin
      r_stErr <= w_abort;
      if (r_state != ST_REQ || w_pop) r_waitCnt <= '0;
      else                            r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end
  end

  assign stErr = r_stErr;
`else
  assign w_abort = 1'b0;
  assign stErr   = 1'b0;
`endif

  assign busReq  = (r_state == ST_REQ);
  assign busAddr = r_busAddr;
  assign busData = r_busData;
  assign stFull  = w_full;
  assign stIdle  = w_empty && (r_state == ST_IDLE);
  assign stOvf   = r_stOvf;

endmodule

`default_nettype wire

// File: tb/tb_acc_store_unit.sv
//==============================================================================
// Module   : tb_acc_store_unit
// Brief    : Directed self-checking bench for acc_store_unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_acc_store_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] accData = '0;
  logic       stEn = 1'b0;
  logic       stNeg = 1'b0;
  logic [7:0] stAddr = '0;
  logic       stFull;
  logic       stIdle;
  logic       stOvf;
  logic       busReq;
  logic [7:0] busAddr;
  logic [7:0] busData;
  logic       busAck = 1'b0;
  logic       stErr;

  int checks = 0;
  int errors = 0;

  acc_store_unit dut (
    .clk     (clk),
    .reset   (reset),
    .accData (accData),
    .stEn    (stEn),
    .stNeg   (stNeg),
    .stAddr  (stAddr),
    .stFull  (stFull),
    .stIdle  (stIdle),
    .stOvf   (stOvf),
    .busReq  (busReq),
    .busAddr (busAddr),
    .busData (busData),
    .busAck  (busAck),
    .stErr   (stErr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d, input logic n);
    stAddr  = a;
    accData = d;
    stNeg   = n;
    stEn    = 1'b1;
    tick();
    stEn    = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkVal("rst busReq", busReq, 0);
    checkVal("rst busAddr", busAddr, 0);
    checkVal("rst busData", busData, 0);
    checkVal("rst stFull", stFull, 0);
    checkVal("rst stIdle", stIdle, 1);
    checkVal("rst stOvf", stOvf, 0);
    checkVal("rst stErr", stErr, 0);

    // single store
    store(8'h10, 8'hA5, 1'b0);
    checkVal("st busReq", busReq, 1);
    checkVal("st busAddr", busAddr, 8'h10);
    checkVal("st busData", busData, 8'hA5);
    checkVal("st stIdle", stIdle, 0);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkVal("st done busReq", busReq, 0);
    checkVal("st done stIdle", stIdle, 1);

    // STN complement captured at store time
    store(8'h22, 8'h3C, 1'b1);
    accData = 8'hFF;
    checkVal("stn busAddr", busAddr, 8'h22);
    checkVal("stn busData", busData, 8'hC3);
    tick();
    checkVal("stn hold busReq", busReq, 1);
    checkVal("stn hold busData", busData, 8'hC3);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkVal("stn done stIdle", stIdle, 1);

    // full and overflow
    store(8'h01, 8'h11, 1'b0);
    checkVal("ovf full1", stFull, 0);
    checkVal("ovf addr1", busAddr, 8'h01);
    store(8'h02, 8'h12, 1'b0);
    checkVal("ovf full2", stFull, 1);
    checkVal("ovf pre stOvf", stOvf, 0);
    store(8'h03, 8'h13, 1'b0);
    checkVal("ovf stOvf", stOvf, 1);
    checkVal("ovf full3", stFull, 1);
    busAck = 1'b1;
    tick();
    checkVal("ovf beat2 busReq", busReq, 1);
    checkVal("ovf beat2 addr", busAddr, 8'h02);
    checkVal("ovf beat2 data", busData, 8'h12);
    checkVal("ovf beat2 full", stFull, 0);
    tick();
    busAck = 1'b0;
    checkVal("ovf drained busReq", busReq, 0);
    checkVal("ovf drained stIdle", stIdle, 1);
    checkVal("ovf sticky", stOvf, 1);
    tick();
    checkVal("ovf no beat3", busReq, 0);

    // back-to-back with ack held high
    busAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stAddr  = 8'h40 + 8'(i);
      accData = 8'(i + 1);
      stNeg   = 1'b0;
      stEn    = 1'b1;
      tick();
      checkVal($sformatf("b2b busReq%0d", i), busReq, 1);
      checkVal($sformatf("b2b addr%0d", i), busAddr, 8'h40 + 8'(i));
      checkVal($sformatf("b2b data%0d", i), busData, 8'(i + 1));
      checkVal($sformatf("b2b full%0d", i), stFull, 0);
    end
    stEn = 1'b0;
    tick();
    busAck = 1'b0;
    checkVal("b2b end busReq", busReq, 0);
    checkVal("b2b end stIdle", stIdle, 1);

    // reset mid-transfer
    store(8'h50, 8'h55, 1'b0);
    store(8'h51, 8'h56, 1'b0);
    checkVal("mid busReq", busReq, 1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("mid async busReq", busReq, 0);
    tick();
    reset = 1'b0;
    tick();
    checkVal("mid stIdle", stIdle, 1);
    checkVal("mid stFull", stFull, 0);
    checkVal("mid stOvf", stOvf, 0);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkVal("mid no beat", busReq, 0);

`ifdef STORE_TIMEOUT_EN
    store(8'h60, 8'h66, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      checkVal("to wait stErr", stErr, 0);
      checkVal("to wait busReq", busReq, 1);
    end
    tick();
    checkVal("to stErr", stErr, 1);
    checkVal("to busReq", busReq, 0);
    tick();
    checkVal("to stErr pulse", stErr, 0);
    checkVal("to stIdle", stIdle, 1);

    store(8'h61, 8'h67, 1'b0);
    repeat (15) tick();
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkVal("to ack stErr", stErr, 0);
    checkVal("to ack busReq", busReq, 0);
    tick();
    checkVal("to ack stErr2", stErr, 0);
`else
    store(8'h60, 8'h66, 1'b0);
    repeat (20) tick();
    checkVal("noto busReq", busReq, 1);
    checkVal("noto stErr", stErr, 0);
    busAck = 1'b1;
    tick();
    busAck = 1'b0;
    checkVal("noto stIdle", stIdle, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
